// File: rtl/mem_write_ctrl.sv
// mem_write_ctrl: CPU store path with posted-write RAM FIFO, LED register,
// unmapped-store error pulse, load/store hazard flag and flush control.
// Ports: clk, reset_n, wr_req/wr_addr/wr_data/wr_ready (store in),
//   flush, rd_addr/rd_hazard (load check), ram_ready/ram_we/ram_waddr/
//   ram_din (RAM drain), led_out, wr_err, empty.
// Option: WR_COALESCE_EN merges a RAM store into the newest matching entry.
module mem_write_ctrl #(
  parameter int              ADDR_W   = 9,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter int              LED_W    = 8,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hazard,
  input  logic              ram_ready,
  output logic              ram_we,
  output logic [ADDR_W-2:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [LED_W-1:0]  led_out,
  output logic              wr_err,
  output logic              empty
);

  localparam int AW = ADDR_W - 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic            err_q, err_d;

  logic          is_ram;
  logic          is_led;
  logic          pop;
  logic          push;
  logic          accept;
  logic          coal;
  logic          hit;
  logic [PW-1:0] idx;
`ifdef WR_COALESCE_EN
  logic [PW-1:0] newest;
`endif

  always_comb begin
    is_ram = !wr_addr[ADDR_W-1];
    is_led = (wr_addr == LED_ADDR) && !is_ram;
    empty  = (count_q == '0);
    ram_we = !empty && ram_ready;
    pop    = ram_we;
    ram_waddr = mem_q[rptr_q].addr;
    ram_din   = mem_q[rptr_q].data;
`ifdef WR_COALESCE_EN
    newest = wptr_q - PW'(1);
    // Never merge into an entry that is leaving the FIFO this cycle.
    coal = wr_req && is_ram && !empty
        && (mem_q[newest].addr == wr_addr[AW-1:0])
        && !((count_q == CW'(1)) && pop);
`else
    coal = 1'b0;
`endif
    wr_ready = (state_q != FLUSH) && ((count_q < FULL) || coal);
    accept   = wr_req && wr_ready;
    push     = accept && is_ram && !coal;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q].addr = wr_addr[AW-1:0];
      mem_d[wptr_q].data = wr_data;
      wptr_d = wptr_q + PW'(1);
    end
`ifdef WR_COALESCE_EN
    if (accept && coal) begin
      mem_d[newest].data = wr_data;
    end
`endif
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    led_d = led_q;
    if (accept && is_led) begin
      led_d = wr_data[LED_W-1:0];
    end
    err_d = accept && !is_ram && !is_led;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = DRAIN;
      end
      DRAIN: begin
        if (count_d == '0) state_d = IDLE;
        else if (flush)    state_d = FLUSH;
      end
      FLUSH: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entries being popped this cycle still count as pending.
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < count_q) && (mem_q[idx].addr == rd_addr[AW-1:0])) begin
        hit = 1'b1;
      end
    end
    rd_hazard = hit && !rd_addr[ADDR_W-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  assign led_out = led_q;
  assign wr_err  = err_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// tb_mem_write_ctrl: vector table, reset/flush sequences and a
// randomized run against a queue-based reference model.
module tb_mem_write_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_req = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        flush = 1'b0;
  logic [8:0]  rd_addr = 9'h1FF;
  logic        rd_hazard;
  logic        ram_ready = 1'b0;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_din;
  logic [7:0]  led_out;
  logic        wr_err;
  logic        empty;

  int nchk = 0;
  int nerr = 0;

  mem_write_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_hazard (rd_hazard),
    .ram_ready (ram_ready),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .led_out   (led_out),
    .wr_err    (wr_err),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [8:0]  addr;
    logic [15:0] data;
    logic        fl;
    logic [8:0]  rd;
    logic        rr;
    logic        rdy;
    logic        we;
    logic [7:0]  wa;
    logic [15:0] din;
    logic        hz;
    logic        emp;
    logic [7:0]  led;
    logic        err;
  } vec_t;

  vec_t vec [22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [8:0] a,
                       input logic [15:0] d, input logic fl,
                       input logic [8:0] rd, input logic rr);
    wr_req = req;
    wr_addr = a;
    wr_data = d;
    flush = fl;
    rd_addr = rd;
    ram_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  qa[$];
  logic [15:0] qd[$];
  logic [7:0]  m_led;
  logic        m_err;
  logic        m_fl;

  initial begin
    vec[0]  = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[1]  = '{1,9'h005,16'hBEEF,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[2]  = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,1,8'h05,16'hBEEF,0,0,8'h00,0};
    vec[3]  = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[4]  = '{1,9'h001,16'h0001,0,9'h1FF,0, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[5]  = '{1,9'h002,16'h0002,0,9'h1FF,0, 1,0,8'h00,16'h0000,0,0,8'h00,0};
    vec[6]  = '{1,9'h003,16'h0003,0,9'h1FF,0, 0,0,8'h00,16'h0000,0,0,8'h00,0};
    vec[7]  = '{1,9'h003,16'h0003,0,9'h1FF,1, 0,1,8'h01,16'h0001,0,0,8'h00,0};
    vec[8]  = '{1,9'h003,16'h0003,0,9'h1FF,1, 1,1,8'h02,16'h0002,0,0,8'h00,0};
    vec[9]  = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,1,8'h03,16'h0003,0,0,8'h00,0};
    vec[10] = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[11] = '{1,9'h100,16'h00A5,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'h00,0};
    vec[12] = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'hA5,0};
    vec[13] = '{1,9'h1F0,16'h1234,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'hA5,0};
    vec[14] = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'hA5,1};
    vec[15] = '{0,9'h000,16'h0000,0,9'h1FF,1, 1,0,8'h00,16'h0000,0,1,8'hA5,0};
    vec[16] = '{1,9'h007,16'h0777,0,9'h007,0, 1,0,8'h00,16'h0000,0,1,8'hA5,0};
    vec[17] = '{0,9'h000,16'h0000,0,9'h007,0, 1,0,8'h00,16'h0000,1,0,8'hA5,0};
    vec[18] = '{0,9'h000,16'h0000,0,9'h008,0, 1,0,8'h00,16'h0000,0,0,8'hA5,0};
    vec[19] = '{0,9'h000,16'h0000,0,9'h107,0, 1,0,8'h00,16'h0000,0,0,8'hA5,0};
    vec[20] = '{0,9'h000,16'h0000,0,9'h007,1, 1,1,8'h07,16'h0777,1,0,8'hA5,0};
    vec[21] = '{0,9'h000,16'h0000,0,9'h007,1, 1,0,8'h00,16'h0000,0,1,8'hA5,0};

    #12 reset_n = 1'b1;
    step();

    for (int i = 0; i < 22; i++) begin
      drive(vec[i].req, vec[i].addr, vec[i].data, vec[i].fl,
            vec[i].rd, vec[i].rr);
      #3;
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(vec[i].rdy));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vec[i].we));
      if (vec[i].we) begin
        chk($sformatf("v%0d ram_waddr", i), 32'(ram_waddr), 32'(vec[i].wa));
        chk($sformatf("v%0d ram_din", i), 32'(ram_din), 32'(vec[i].din));
      end
      chk($sformatf("v%0d rd_hazard", i), 32'(rd_hazard), 32'(vec[i].hz));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vec[i].emp));
      chk($sformatf("v%0d led_out", i), 32'(led_out), 32'(vec[i].led));
      chk($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vec[i].err));
      step();
    end

    // Reset while two entries are pending and RAM is ready.
    drive(1, 9'h001, 16'h1111, 0, 9'h1FF, 0);
    step();
    drive(1, 9'h002, 16'h2222, 0, 9'h1FF, 0);
    step();
    drive(0, 9'h000, 16'h0000, 0, 9'h1FF, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst empty", 32'(empty), 32'(1));
    chk("rst ram_we", 32'(ram_we), 32'(0));
    chk("rst led_out", 32'(led_out), 32'(0));
    chk("rst wr_ready", 32'(wr_ready), 32'(1));
    step();
    chk("rst edge ram_we", 32'(ram_we), 32'(0));
    reset_n = 1'b1;
    step();
    chk("post rst empty", 32'(empty), 32'(1));
    chk("post rst ram_we", 32'(ram_we), 32'(0));

    // Flush with two entries and a store held pending.
    drive(1, 9'h010, 16'h0010, 0, 9'h1FF, 0);
    step();
    drive(1, 9'h011, 16'h0011, 0, 9'h1FF, 0);
    step();
    drive(1, 9'h012, 16'h0012, 1, 9'h1FF, 0);
    #3;
    chk("fl c0 wr_ready", 32'(wr_ready), 32'(0));
    step();
    ram_ready = 1'b1;
    #3;
    chk("fl c1 wr_ready", 32'(wr_ready), 32'(0));
    chk("fl c1 ram_waddr", 32'(ram_waddr), 32'(8'h10));
    step();
    #3;
    chk("fl c2 wr_ready", 32'(wr_ready), 32'(0));
    chk("fl c2 ram_waddr", 32'(ram_waddr), 32'(8'h11));
    chk("fl c2 empty", 32'(empty), 32'(0));
    step();
    #3;
    chk("fl c3 empty", 32'(empty), 32'(1));
    chk("fl c3 wr_ready", 32'(wr_ready), 32'(1));
    step();
    drive(0, 9'h000, 16'h0000, 0, 9'h1FF, 1);
    #3;
    chk("fl c4 ram_we", 32'(ram_we), 32'(1));
    chk("fl c4 ram_waddr", 32'(ram_waddr), 32'(8'h12));
    chk("fl c4 ram_din", 32'(ram_din), 32'(16'h0012));
    step();
    step();

    // Randomized run against the queue model.
    m_led = 8'h00;
    m_err = 1'b0;
    m_fl  = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic        r_req, r_fl, r_rr;
      logic [8:0]  r_a, r_rd;
      logic [15:0] r_d;
      logic        e_rdy, e_we, e_hz, acc;
      int          sel, old;
      r_req = ($urandom % 4) != 0;
      r_fl  = ($urandom % 8) == 0;
      r_rr  = 1'($urandom % 2);
      r_d   = 16'($urandom);
      sel   = $urandom % 10;
      if (sel < 7)       r_a = {6'b0, 3'($urandom)};
      else if (sel == 7) r_a = 9'h100;
      else               r_a = {1'b1, 8'($urandom_range(1, 255))};
      r_rd = ($urandom % 5 == 0) ? {1'b1, 8'($urandom % 8)}
                                 : {6'b0, 3'($urandom)};
      drive(r_req, r_a, r_d, r_fl, r_rd, r_rr);

      e_rdy = !m_fl && (qa.size() < 2);
      e_we  = (qa.size() > 0) && r_rr;
      e_hz  = 1'b0;
      foreach (qa[k]) if (!r_rd[8] && qa[k] == r_rd[7:0]) e_hz = 1'b1;
      #3;
      chk("rnd wr_ready", 32'(wr_ready), 32'(e_rdy));
      chk("rnd ram_we", 32'(ram_we), 32'(e_we));
      if (e_we) begin
        chk("rnd ram_waddr", 32'(ram_waddr), 32'(qa[0]));
        chk("rnd ram_din", 32'(ram_din), 32'(qd[0]));
      end
      chk("rnd rd_hazard", 32'(rd_hazard), 32'(e_hz));
      chk("rnd empty", 32'(empty), 32'(qa.size() == 0));
      chk("rnd led_out", 32'(led_out), 32'(m_led));
      chk("rnd wr_err", 32'(wr_err), 32'(m_err));

      acc = r_req && e_rdy;
      old = qa.size();
      if (e_we) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (acc && !r_a[8]) begin
        qa.push_back(r_a[7:0]);
        qd.push_back(r_d);
      end
      if (acc && r_a == 9'h100) m_led = r_d[7:0];
      m_err = acc && r_a[8] && (r_a != 9'h100);
      m_fl  = (qa.size() != 0) && (m_fl || (r_fl && old > 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
